// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every signal between the core back end, the memory bus and the
//   memory port arbiter.
//   slave  : arbiter side (takes requests and memory replies, drives grants,
//            the memory command, routed responses and hazard status)
//   master : core/memory side (the mirror image)
//   Request side  : st_*, ld_*, if_* request/address/size/data and grants
//   Response side : ld_resp_*, if_resp_*
//   Memory side   : proc2mem_* command bus, mem2proc_* response/tag/data
//   Status        : if_mem_hazard, Dmem_wait, outstanding_full, err_tag
interface mem_port_arbiter_if #(
  parameter int XLEN = 32,
  parameter int TW   = 4
);
  logic            st_req;
  logic [XLEN-1:0] st_addr;
  logic [63:0]     st_data;
  logic [1:0]      st_size;
  logic            st_gnt;

  logic            ld_req;
  logic [XLEN-1:0] ld_addr;
  logic [1:0]      ld_size;
  logic            ld_gnt;
  logic            ld_resp_valid;
  logic [63:0]     ld_resp_data;

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_resp_valid;
  logic [63:0]     if_resp_data;

  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [1:0]      proc2mem_size;
  logic [TW-1:0]   mem2proc_response;
  logic [TW-1:0]   mem2proc_tag;
  logic [63:0]     mem2proc_data;

  logic            if_mem_hazard;
  logic            Dmem_wait;
  logic            outstanding_full;
  logic            err_tag;

  modport slave (
    input  st_req, st_addr, st_data, st_size,
    input  ld_req, ld_addr, ld_size,
    input  if_req, if_addr,
    input  mem2proc_response, mem2proc_tag, mem2proc_data,
    output st_gnt, ld_gnt, ld_resp_valid, ld_resp_data,
    output if_gnt, if_resp_valid, if_resp_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output if_mem_hazard, Dmem_wait, outstanding_full, err_tag
  );

  modport master (
    output st_req, st_addr, st_data, st_size,
    output ld_req, ld_addr, ld_size,
    output if_req, if_addr,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input  st_gnt, ld_gnt, ld_resp_valid, ld_resp_data,
    input  if_gnt, if_resp_valid, if_resp_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  if_mem_hazard, Dmem_wait, outstanding_full, err_tag
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single processor-to-memory port between store commit, load
//   buffer reads and instruction fetch. Priority is store > load > fetch,
//   except that a fetch denied STARVE_LIMIT cycles in a row outranks loads.
//   Accepted loads/fetches are remembered by memory tag so completions can be
//   routed back to their owner in the cycle they arrive.
// Ports
//   clock : system clock, all state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requests, grants, memory command and
//           reply, routed responses, hazard/status outputs)
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int NUM_TAGS        = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_LOAD    = 2'd1;
  localparam logic [1:0] CMD_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  typedef enum logic [1:0] {SEL_NONE, SEL_ST, SEL_LD, SEL_IF} sel_e;

  // Tag table: valid bit plus owner bit (1 = fetch, 0 = load)
  logic [NUM_TAGS-1:0] tag_vld_q, tag_vld_d;
  logic [NUM_TAGS-1:0] tag_fch_q, tag_fch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                err_q, err_d;

  sel_e                sel;
  logic                full;
  logic                accepted;
  logic                issue_tbl;
  logic                tag_nz;
  logic                cmp_hit;
  logic                cmp_bad;
  logic                cmp_fch;
  logic [1:0]          cmd;
  logic [XLEN-1:0]     addr;
  logic [63:0]         data;
  logic [1:0]          size;

  assign full = (cnt_q == CW'(MAX_OUTSTANDING));

  // Requester selection. While reset is asserted nothing is selected so the
  // port and every grant read zero immediately.
  always_comb begin
    sel = SEL_NONE;
    if (reset) begin
      if (bus.st_req)
        sel = SEL_ST;
      else if ((starve_q == SW'(STARVE_LIMIT)) && bus.if_req && !full)
        sel = SEL_IF;
      else if (bus.ld_req && !full)
        sel = SEL_LD;
      else if (bus.if_req && !full)
        sel = SEL_IF;
    end
  end

  always_comb begin
    cmd  = CMD_NONE;
    addr = '0;
    data = '0;
    size = '0;
    unique case (sel)
      SEL_ST: begin
        cmd  = CMD_STORE;
        addr = bus.st_addr;
        data = bus.st_data;
        size = bus.st_size;
      end
      SEL_LD: begin
        cmd  = CMD_LOAD;
        addr = bus.ld_addr;
        size = bus.ld_size;
      end
      SEL_IF: begin
        cmd  = CMD_LOAD;
        addr = bus.if_addr;
        size = SIZE_DOUBLE;
      end
      default: ;
    endcase
  end

  assign accepted  = (sel != SEL_NONE) && (bus.mem2proc_response != '0);
  assign issue_tbl = accepted && ((sel == SEL_LD) || (sel == SEL_IF));

  // Completion lookup uses the registered table, so a completion whose tag is
  // reissued in the same cycle is routed with the pre-update owner.
  assign tag_nz  = (bus.mem2proc_tag != '0);
  assign cmp_hit = tag_nz && tag_vld_q[bus.mem2proc_tag];
  assign cmp_bad = tag_nz && !tag_vld_q[bus.mem2proc_tag];
  assign cmp_fch = tag_fch_q[bus.mem2proc_tag];

  assign bus.proc2mem_command = cmd;
  assign bus.proc2mem_addr    = addr;
  assign bus.proc2mem_data    = data;
  assign bus.proc2mem_size    = size;

  assign bus.st_gnt = accepted && (sel == SEL_ST);
  assign bus.ld_gnt = accepted && (sel == SEL_LD);
  assign bus.if_gnt = accepted && (sel == SEL_IF);

  assign bus.ld_resp_valid = cmp_hit && !cmp_fch;
  assign bus.ld_resp_data  = (cmp_hit && !cmp_fch) ? bus.mem2proc_data : '0;
  assign bus.if_resp_valid = cmp_hit && cmp_fch;
  assign bus.if_resp_data  = (cmp_hit && cmp_fch) ? bus.mem2proc_data : '0;

  assign bus.if_mem_hazard    = (sel == SEL_ST) || (sel == SEL_LD);
  assign bus.Dmem_wait        = bus.ld_req && !bus.ld_gnt;
  assign bus.outstanding_full = full;
  assign bus.err_tag          = err_q;

  // Next-state: table (issue overrides a same-cycle clear), in-flight count,
  // fetch starvation count and sticky tag error.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_fch_d = tag_fch_q;
    cnt_d     = cnt_q;
    starve_d  = '0;
    err_d     = err_q | cmp_bad;

    if (cmp_hit)
      tag_vld_d[bus.mem2proc_tag] = 1'b0;
    if (issue_tbl) begin
      tag_vld_d[bus.mem2proc_response] = 1'b1;
      tag_fch_d[bus.mem2proc_response] = (sel == SEL_IF);
    end

    if (issue_tbl && !cmp_hit && (cnt_q != CW'(MAX_OUTSTANDING)))
      cnt_d = cnt_q + CW'(1);
    else if (!issue_tbl && cmp_hit && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);

    if (bus.if_req && !bus.if_gnt)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_fch_q <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_fch_q <= tag_fch_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single processor-to-memory port between three requesters: store commit (ROB head), load buffer reads, and instruction fetch.
- Fixed priority is store > load > fetch, with a starvation boost for fetch.
- Tracks outstanding load/fetch tags and routes memory responses back to their owner.
- Produces the if_mem_hazard and Dmem_wait signals consumed by the hazard detection unit; sits between the core back end and the memory bus.

Parameters:
XLEN, 32, address width
NUM_TAGS, 16, memory tag space; tag width TW = $clog2(NUM_TAGS); tag 0 is reserved (no response / rejected)
MAX_OUTSTANDING, 8, maximum in-flight loads plus fetches
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch outranks load

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted at 0, deasserts synchronously to clock)
st_req  input  1  commit store wants the port; held until st_gnt
st_addr  input  XLEN  store address
st_data  input  64  store data
st_size  input  2  BYTE/HALF/WORD/DOUBLE
st_gnt  output  1  store accepted by memory this cycle
ld_req  input  1  load buffer read request; held until ld_gnt
ld_addr  input  XLEN  load address
ld_size  input  2  load size
ld_gnt  output  1  load accepted this cycle
ld_resp_valid  output  1  load data returned this cycle
ld_resp_data  output  64  returned load data
if_req  input  1  fetch request; held until if_gnt
if_addr  input  XLEN  fetch address
if_gnt  output  1  fetch accepted this cycle
if_resp_valid  output  1  fetch data returned this cycle
if_resp_data  output  64  returned fetch data
proc2mem_command  output  2  NONE=0, LOAD=1, STORE=2
proc2mem_addr  output  XLEN  address of granted requester
proc2mem_data  output  64  st_data when the command is STORE, else 0
proc2mem_size  output  2  size of granted requester (DOUBLE for fetch)
mem2proc_response  input  TW  issue tag; 0 = rejected; combinational from the command
mem2proc_tag  input  TW  completing tag; 0 = none
mem2proc_data  input  64  completing data
if_mem_hazard  output  1  port is selected for store or load this cycle (fetch blocked)
Dmem_wait  output  1  ld_req high and ld_gnt low
outstanding_full  output  1  in-flight count == MAX_OUTSTANDING
err_tag  output  1  sticky: completion arrived for a tag not in the table

Behaviour:
- Selection is combinational each cycle, evaluated in this order:
  - st_req wins.
  - Else, if starve_cnt == STARVE_LIMIT and if_req, fetch wins.
  - Else ld_req wins.
  - Else if_req wins.
- Load and fetch are ineligible while outstanding_full; stores remain eligible.
- Memory command is driven from the selected requester; no requester selected gives command NONE, addr/data/size 0.
- Grant: *_gnt = selected & (mem2proc_response != 0). A response of 0 means rejected: no grant, no state change, and the requester retries next cycle.
- Tag table: NUM_TAGS entries of {valid, owner(LD/IF)}.
  - Accepted load/fetch sets table[response] = {1, owner}.
  - An accepted store creates no entry.
- Completion: mem2proc_tag != 0 with table[tag].valid:
  - Route data to the owner's *_resp_valid / *_resp_data in the same cycle (combinational).
  - Clear the entry.
- Completion with tag != 0 and the entry invalid: no routing, err_tag set until reset.
- Same cycle completion of tag T and issue reusing T: the issue's set wins and the completion is routed using the pre-update owner.
- In-flight counter (0..MAX_OUTSTANDING):
  - +1 on accepted load/fetch; -1 on routed completion.
  - Both in the same cycle: unchanged.
  - Never wraps.
- starve_cnt:
  - +1, saturating at STARVE_LIMIT, when if_req & ~if_gnt.
  - Cleared when if_gnt or ~if_req.
- if_mem_hazard = (store or load selected); Dmem_wait = ld_req & ~ld_gnt.
- Reset (asynchronous, reset==0): tag table invalid, counter 0, starve_cnt 0, err_tag 0.
  - All outputs are then 0: command NONE, all grants/resp_valid 0, if_mem_hazard 0, Dmem_wait 0 unless ld_req high.
  - Reset mid-transaction drops all in-flight tags; later completions for those tags raise err_tag only after reset deasserts.

Test Plan:
- st_req, ld_req, if_req all high, response=3 -> command STORE, st_gnt=1, ld_gnt=0, if_gnt=0, if_mem_hazard=1, Dmem_wait=1, no table entry.
- ld_req at 0x100, response=5; 4 cycles later mem2proc_tag=5, data=0xDEAD -> ld_resp_valid=1, ld_resp_data=0xDEAD, counter back to 0.
- ld_req and if_req held high, response always nonzero -> load wins cycles 0-3; cycle 4 (starve_cnt=4) if_gnt=1, then starve_cnt=0.
- Issue 8 fetches with tags 1-8 and no completions -> outstanding_full=1, ld_req denied, st_req still granted; completion of tag 2 -> next load issues.
- response=0 while ld_req high -> ld_gnt=0, Dmem_wait=1, counter unchanged; mem2proc_tag=9 never issued -> err_tag=1 and stays 1.
- Drive reset=0 mid-flight with 3 tags outstanding -> all outputs 0 immediately (async), counter 0; tag=1 arriving after release -> err_tag=1.
